// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - Pong game sequencer: paddles, ball, scores, serve/play/point/game-over
module pong_game_ctrl #(
    parameter int PADDLE_H    = 8,
    parameter int SERVE_TICKS = 30,
    parameter int POINT_TICKS = 15,
    parameter int WIN_SCORE   = 9
) (
    input  logic       board_clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       l_up,
    input  logic       l_dn,
    input  logic       r_up,
    input  logic       r_dn,
    output logic [5:0] paddle_l,
    output logic [5:0] paddle_r,
    output logic [5:0] ball_x,
    output logic [5:0] ball_y,
    output logic       ball_vis,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic [2:0] state,
    output logic       game_over
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SERVE    = 3'd1;
    localparam logic [2:0] ST_PLAY     = 3'd2;
    localparam logic [2:0] ST_POINT    = 3'd3;
    localparam logic [2:0] ST_GAMEOVER = 3'd4;

    localparam logic [5:0] PAD_MAX   = 6'(64 - PADDLE_H);
    localparam logic [6:0] PAD_SPAN  = 7'(PADDLE_H - 1);
    localparam logic [4:0] SERVE_END = 5'(SERVE_TICKS - 1);
    localparam logic [4:0] POINT_END = 5'(POINT_TICKS - 1);
    localparam logic [3:0] WIN       = 4'(WIN_SCORE);

    // Bit order {start, l_up, l_dn, r_up, r_dn}
    logic [4:0] sync1_q, sync2_q;
    logic       start_s, l_up_s, l_dn_s, r_up_s, r_dn_s;

    // Direction flags: 1 means +1, 0 means -1
    logic [5:0] paddle_l_q, paddle_l_d, paddle_r_q, paddle_r_d;
    logic [5:0] ball_x_q, ball_x_d, ball_y_q, ball_y_d;
    logic       dx_q, dx_d, dy_q, dy_d, serve_dx_q, serve_dx_d;
    logic [3:0] score_l_q, score_l_d, score_r_q, score_r_d;
    logic [2:0] state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic       ball_vis_q, ball_vis_d, game_over_q, game_over_d;
    logic [6:0] l_top, l_bot, r_top, r_bot, y_ext;
    logic       hit_l, hit_r;

    assign {start_s, l_up_s, l_dn_s, r_up_s, r_dn_s} = sync2_q;

    function automatic logic [5:0] paddle_next(input logic [5:0] pos, input logic up, input logic dn);
        if (up && !dn && pos != 6'd0)
            return pos - 6'd1;
        else if (dn && !up && pos < PAD_MAX)
            return pos + 6'd1;
        else
            return pos;
    endfunction

    // Paddle coverage uses the pre-tick paddle and ball row
    always_comb begin
        y_ext = {1'b0, ball_y_q};
        l_top = {1'b0, paddle_l_q};
        l_bot = l_top + PAD_SPAN;
        r_top = {1'b0, paddle_r_q};
        r_bot = r_top + PAD_SPAN;
        hit_l = (y_ext >= l_top) && (y_ext <= l_bot);
        hit_r = (y_ext >= r_top) && (y_ext <= r_bot);
    end

    // Two-flop synchronizers for the switch and buttons
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 5'd0;
            sync2_q <= 5'd0;
        end else begin
            sync1_q <= {start, l_up, l_dn, r_up, r_dn};
            sync2_q <= sync1_q;
        end
    end

    // Next-state game logic; everything holds unless tick is high
    always_comb begin
        paddle_l_d = paddle_l_q;
        paddle_r_d = paddle_r_q;
        ball_x_d   = ball_x_q;
        ball_y_d   = ball_y_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        serve_dx_d = serve_dx_q;
        score_l_d  = score_l_q;
        score_r_d  = score_r_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        if (tick) begin
            paddle_l_d = paddle_next(paddle_l_q, l_up_s, l_dn_s);
            paddle_r_d = paddle_next(paddle_r_q, r_up_s, r_dn_s);
            case (state_q)
                ST_IDLE: begin
                    if (start_s) begin
                        state_d  = ST_SERVE;
                        ball_x_d = 6'd32;
                        ball_y_d = 6'd32;
                        cnt_d    = 5'd0;
                    end
                end
                ST_SERVE: begin
                    ball_x_d = 6'd32;
                    ball_y_d = 6'd32;
                    if (cnt_q == SERVE_END) begin
                        state_d = ST_PLAY;
                        cnt_d   = 5'd0;
                        dy_d    = 1'b1;
                        dx_d    = serve_dx_q;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                ST_PLAY: begin
                    if (ball_y_q == 6'd0 && !dy_q) begin
                        dy_d     = 1'b1;
                        ball_y_d = 6'd1;
                    end else if (ball_y_q == 6'd63 && dy_q) begin
                        dy_d     = 1'b0;
                        ball_y_d = 6'd62;
                    end else begin
                        ball_y_d = dy_q ? ball_y_q + 6'd1 : ball_y_q - 6'd1;
                    end
                    if (ball_x_q == 6'd1 && !dx_q) begin
                        if (hit_l) begin
                            dx_d     = 1'b1;
                            ball_x_d = 6'd2;
                        end else begin
                            ball_x_d   = 6'd0;
                            score_r_d  = score_r_q + 4'd1;
                            serve_dx_d = 1'b0;
                            state_d    = ST_POINT;
                        end
                    end else if (ball_x_q == 6'd62 && dx_q) begin
                        if (hit_r) begin
                            dx_d     = 1'b0;
                            ball_x_d = 6'd61;
                        end else begin
                            ball_x_d   = 6'd63;
                            score_l_d  = score_l_q + 4'd1;
                            serve_dx_d = 1'b1;
                            state_d    = ST_POINT;
                        end
                    end else begin
                        ball_x_d = dx_q ? ball_x_q + 6'd1 : ball_x_q - 6'd1;
                    end
                end
                ST_POINT: begin
                    if (cnt_q == POINT_END) begin
                        cnt_d = 5'd0;
                        if (score_l_q == WIN || score_r_q == WIN) begin
                            state_d = ST_GAMEOVER;
                        end else begin
                            state_d  = ST_SERVE;
                            ball_x_d = 6'd32;
                            ball_y_d = 6'd32;
                        end
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                ST_GAMEOVER: begin
                    if (start_s) begin
                        state_d    = ST_SERVE;
                        score_l_d  = 4'd0;
                        score_r_d  = 4'd0;
                        serve_dx_d = 1'b1;
                        ball_x_d   = 6'd32;
                        ball_y_d   = 6'd32;
                        cnt_d      = 5'd0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        ball_vis_d  = (state_d == ST_SERVE) || (state_d == ST_PLAY) || (state_d == ST_POINT);
        game_over_d = (state_d == ST_GAMEOVER);
    end

    // Game state registers with asynchronous reset to the power-on layout
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            paddle_l_q  <= 6'd28;
            paddle_r_q  <= 6'd28;
            ball_x_q    <= 6'd32;
            ball_y_q    <= 6'd32;
            dx_q        <= 1'b1;
            dy_q        <= 1'b1;
            serve_dx_q  <= 1'b1;
            score_l_q   <= 4'd0;
            score_r_q   <= 4'd0;
            state_q     <= ST_IDLE;
            cnt_q       <= 5'd0;
            ball_vis_q  <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            paddle_l_q  <= paddle_l_d;
            paddle_r_q  <= paddle_r_d;
            ball_x_q    <= ball_x_d;
            ball_y_q    <= ball_y_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            serve_dx_q  <= serve_dx_d;
            score_l_q   <= score_l_d;
            score_r_q   <= score_r_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ball_vis_q  <= ball_vis_d;
            game_over_q <= game_over_d;
        end
    end

    assign paddle_l  = paddle_l_q;
    assign paddle_r  = paddle_r_q;
    assign ball_x    = ball_x_q;
    assign ball_y    = ball_y_q;
    assign ball_vis  = ball_vis_q;
    assign score_l   = score_l_q;
    assign score_r   = score_r_q;
    assign state     = state_q;
    assign game_over = game_over_q;

endmodule
